ps2_receiver: RTL

//  PS/2 device-to-host frame receiver between the PS/2 debouncer and the SoC keyboard port.

---
 rtl/ps2_receiver_pkg.sv | 25 ++
 rtl/ps2_fifo.sv | 60 ++++++
 rtl/ps2_receiver.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_receiver_pkg.sv
// Purpose: shared PS/2 receiver definitions (FSM states, frame constants, prefix codes).
// Latency: n/a (types, constants and a parity helper only).
// Backpressure: n/a.
package ps2_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Full frame: start, 8 data, parity, stop.
    localparam int PS2_FRAME_BITS = 11;
    // Bits captured after the start bit: data, parity, stop.
    localparam int PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    // PS/2 uses odd parity over data+parity.
    function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
        return ^{dat, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Purpose: generic synchronous FIFO, WIDTH x DEPTH (DEPTH power of two, >= 2).
// Latency: push visible at pop_dat_o/empty_o one cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
// Ports: clk, rst_n (async active-low), push_i/push_dat_i, pop_i, pop_dat_o (head), full_o, empty_o.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == CW'(DEPTH));
    assign do_pop    = pop_i & ~empty_o;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push   = push_i & (~full_o | do_pop);
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// Purpose: PS/2 device-to-host frame receiver with start/parity/stop checks and an output FIFO.
// Latency: stop-bit fall detected in cycle N -> CHECK in N+1 -> rxValid in N+2 (empty FIFO).
// Backpressure: rxValid/rxReady pop; a good byte arriving while full is dropped with an overflow pulse.
// Ports: clk, reset (async active-low), ps2Clk/ps2Data (async, debounced), rxData/rxExtended/rxBreak/
//        rxValid/rxReady (FIFO head + handshake), parityError/frameError/overflow (1-cycle pulses), busy.
// Option: define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into rxExtended/rxBreak.
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] rxData,
    output logic       rxExtended,
    output logic       rxBreak,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       parityError,
    output logic       frameError,
    output logic       overflow,
    output logic       busy
);

`ifdef PS2_PREFIX_DECODE_EN
    localparam int FIFO_W = 10;
`else
    localparam int FIFO_W = 8;
`endif
    localparam int         TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0] LAST_BIT = 4'(PS2_SHIFT_BITS - 1);

    // Line synchronisers; reset to the idle-high level so reset release never looks like a fall.
    logic clk_meta_q, clk_sync_q, clk_hist_q;
    logic dat_meta_q, dat_sync_q;
    logic fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_hist_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2Clk;
            clk_sync_q <= clk_meta_q;
            clk_hist_q <= clk_sync_q;
            dat_meta_q <= ps2Data;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall = clk_hist_q & ~clk_sync_q;

    state_t                    state_q, state_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [PS2_SHIFT_BITS-1:0] shift_q, shift_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      perr_q, perr_d;
    logic                      ferr_q, ferr_d;
    logic                      ovf_q, ovf_d;
    logic                      byte_good;
    logic                      push_req;
    logic [FIFO_W-1:0]         push_dat;
    logic [FIFO_W-1:0]         pop_dat;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [7:0]                rx_byte;

    // Shift register fills from the top, so after 10 samples: [7:0] data, [8] parity, [9] stop.
    assign rx_byte = shift_q[7:0];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        byte_good = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                // A fall with data high is not a start bit; ignore it silently.
                if (fall && !dat_sync_q) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    shift_d = {dat_sync_q, shift_q[PS2_SHIFT_BITS-1:1]};
                    tmo_d   = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                    ferr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!shift_q[9]) begin
                    ferr_d = 1'b1;
                end else if (!odd_parity_ok(rx_byte, shift_q[8])) begin
                    perr_d = 1'b1;
                end else begin
                    byte_good = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef PS2_PREFIX_DECODE_EN
    logic ext_q, ext_d;
    logic brk_q, brk_d;

    // Prefixes are absorbed into flags; the next good byte carries them and clears them
    // whether it is stored or dropped for overflow. Any bad frame also clears them.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        push_req = 1'b0;
        if (perr_d || ferr_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_good) begin
            if (rx_byte == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_PREFIX_BREAK) begin
                brk_d = 1'b1;
            end else begin
                push_req = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end

    assign push_dat   = {brk_q, ext_q, rx_byte};
    assign rxData     = pop_dat[7:0];
    assign rxExtended = pop_dat[8];
    assign rxBreak    = pop_dat[9];
`else
    assign push_req   = byte_good;
    assign push_dat   = rx_byte;
    assign rxData     = pop_dat;
    assign rxExtended = 1'b0;
    assign rxBreak    = 1'b0;
`endif

    // When full, the head is valid, so rxReady alone decides whether a slot frees up.
    assign ovf_d = push_req & fifo_full & ~rxReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    ps2_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (push_req),
        .push_dat_i (push_dat),
        .pop_i      (rxReady),
        .pop_dat_o  (pop_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign rxValid     = ~fifo_empty;
    assign parityError = perr_q;
    assign frameError  = ferr_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
